// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//   Turns one debounced, clk-synchronous button level into single-cycle event
//   pulses: press, release, short press, long press and optional auto-repeat.
//   All outputs are registered. Each pulse is high for the cycle that follows
//   the edge on which `in` was sampled.
//
// Configuration macro:
//   BUTTON_EVENT_REPEAT_EN  defined   -> HOLD runs the repeat counter, repeat_o
//                                        pulses every REPEAT_PERIOD cycles
//                           undefined -> repeat logic removed, repeat_o = 0
//
// Parameters:
//   LONG_DELAY     cycles from press to long_o (>= 2)
//   REPEAT_PERIOD  cycles between repeat_o pulses (>= 1)
//   CNT_W          counter width, holds max(LONG_DELAY,REPEAT_PERIOD)-1
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   in         debounced button level, 1 = pressed
//   press_o    1-cycle pulse on press
//   release_o  1-cycle pulse on release
//   short_o    1-cycle pulse, released before the long threshold
//   long_o     1-cycle pulse, held LONG_DELAY cycles
//   repeat_o   1-cycle pulse every REPEAT_PERIOD while held after long
//   held_o     level, 1 while the button is considered pressed
// -----------------------------------------------------------------------------
module button_event #(
    parameter int LONG_DELAY    = 62500000,
    parameter int REPEAT_PERIOD = 12500000,
    parameter int CNT_W         = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    // Elaboration-time sanity checks on the parameter set.
    if (LONG_DELAY < 2) begin : g_bad_long
        $error("button_event: LONG_DELAY must be >= 2");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("button_event: REPEAT_PERIOD must be >= 1");
    end
    if ((((LONG_DELAY - 1) >> CNT_W) != 0) ||
        (((REPEAT_PERIOD - 1) >> CNT_W) != 0)) begin : g_bad_cntw
        $error("button_event: CNT_W too small for the thresholds");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DELAY - 1);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,   // after reset: ignore the button until it is released
        IDLE     = 2'd1,
        PRESS    = 2'd2,   // pressed, long threshold not yet reached
        HOLD     = 2'd3    // pressed past the long threshold
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             short_q,   short_d;
    logic             long_q,    long_d;
    logic             held_q,    held_d;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic             repeat_q,  repeat_d;
`endif

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_REL;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-output logic. Release is tested first in PRESS and
    // HOLD so that a release on a threshold edge suppresses long/repeat.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        held_d    = held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            WAIT_REL: begin
                held_d = 1'b0;
                if (!in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (in) begin
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (!in) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!in) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
`ifdef BUTTON_EVENT_REPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign short_o   = short_q;
    assign long_o    = long_q;
    assign held_o    = held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
    assign repeat_o  = repeat_q;
`else
    assign repeat_o  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic press_o, release_o, short_o, long_o, repeat_o, held_o;

    always #5 clk = ~clk;

    button_event #(.LONG_DELAY(L), .REPEAT_PERIOD(R), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (btn),
        .press_o   (press_o),
        .release_o (release_o),
        .short_o   (short_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .held_o    (held_o)
    );

    // exp bit order: {press, release, short, long, repeat, held}
    typedef struct {
        logic       in;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sb[$];
    string      sbn[$];
    int         checks = 0;
    int         errors = 0;

    wire [5:0] act = {press_o, release_o, short_o, long_o, repeat_o, held_o};

    function automatic void add(input logic i, input logic [5:0] e, input string n);
        vec_t v;
        v.in = i; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input int k, input string n);
        for (int j = 0; j < k; j++) add(1'b0, 6'b0, n);
    endfunction

    // Button held for n cycles (in=1 at relative edges 0..n-1); if rel, in=0
    // at edge n. Expected events derived from the timing rules directly.
    function automatic void add_press(input int n, input bit rel, input string tag);
        logic p, lg, rp;
        for (int j = 0; j < n; j++) begin
            p  = (j == 0);
            lg = (j == L);
            rp = REP_EN && (j > L) && (((j - L) % R) == 0);
            add(1'b1, {p, 1'b0, 1'b0, lg, rp, 1'b1}, $sformatf("%s_c%0d", tag, j));
        end
        if (rel) add(1'b0, {1'b0, 1'b1, (n <= L), 1'b0, 1'b0, 1'b0}, $sformatf("%s_rel", tag));
    endfunction

    task automatic check(input logic [5:0] exp, input string n);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", n, act, exp);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            btn = vecs[i].in;
            sb.push_back(vecs[i].exp);
            sbn.push_back(vecs[i].name);
            @(posedge clk);
            #1;
            check(sb.pop_front(), sbn.pop_front());
        end
        vecs.delete();
    endtask

    initial begin
        // reset state
        #12;
        check(6'b0, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        add_idle(2, "wait_rel");
        run_vecs();

        // main table: short, long+repeat, coincident release, spacing
        add_idle(3, "idle0");
        add_press(3, 1'b1, "short3");
        add_idle(3, "idle1");
        add_press(21, 1'b1, "long21");
        add_idle(2, "idle2");
        add_press(8, 1'b1, "coinc8");
        add_idle(2, "idle3");
        add_press(9, 1'b1, "long9");
        add_press(1, 1'b1, "min1");
        add_press(2, 1'b1, "b2b2");
        add_idle(2, "idle4");
        add_press(12, 1'b1, "repcoinc12");
        add_idle(2, "idle5");
        run_vecs();

        // button held through reset deassertion
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 1'b1;
        #1;
        check(6'b0, "rst_in_high");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) add(1'b1, 6'b0, "held_thru_rst");
        add_idle(3, "wr_released");
        add_press(2, 1'b1, "after_wr");
        add_idle(1, "idle6");
        run_vecs();

        // reset while in HOLD
        add_press(11, 1'b0, "to_hold");
        run_vecs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(6'b0, "rst_in_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) add(1'b1, 6'b0, "hold_after_rst");
        add_idle(2, "rel_after_rst");
        add_press(3, 1'b1, "repress");
        add_idle(1, "idle7");
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
